ttt_turn_controller: RTL and testbench

- Turn sequencer and arbiter between two player request ports (X and O) and the shared tic_tac_toe board engine.
- Enforces strict X/O alternation, validates each requested cell against the board occupancy mask, and drives the board's play/pos_playX/pos_play0 inputs with fixed hold and settle timing.
- Samples the board's win code, counts moves, detects a draw, and enforces a per-turn timeout.

---
 rtl/ttt_turn_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_ttt_turn_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_controller.sv
// Turn sequencer between the X and O request ports and the tic-tac-toe board.
// Alternates turns, validates cells, strobes moves, detects win/draw and turn timeouts.
module ttt_turn_controller #(
  parameter int PLAY_HOLD     = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int TURN_TIMEOUT  = 200,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       reqX,
  input  logic [3:0] posX,
  input  logic       reqO,
  input  logic [3:0] posO,
  input  logic [8:0] board_occ,
  input  logic [1:0] win_in,
  output logic       ackX,
  output logic       ackO,
  output logic       nackX,
  output logic       nackO,
  output logic       board_rst,
  output logic       play,
  output logic [3:0] pos_playX,
  output logic [3:0] pos_play0,
  output logic [1:0] turn,
  output logic [3:0] move_cnt,
  output logic       timeout,
  output logic       game_over,
  output logic [1:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    WAIT_O,
    ISSUE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLAY_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TURN_TIMEOUT - 1);

  localparam logic [1:0] TURN_NONE = 2'b00;
  localparam logic [1:0] TURN_X    = 2'b01;
  localparam logic [1:0] TURN_O    = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       turn_q, turn_d;
  logic [3:0]       moveCnt_q, moveCnt_d;
  logic [1:0]       result_q, result_d;
  logic [3:0]       posPlayX_q, posPlayX_d;
  logic [3:0]       posPlayO_q, posPlayO_d;
  logic             ackX_q, ackX_d;
  logic             ackO_q, ackO_d;
  logic             nackX_q, nackX_d;
  logic             nackO_q, nackO_d;
  logic             timeout_q, timeout_d;
  logic             boardRst_q, boardRst_d;

  logic validX, validO, expired;

  // The occupancy mask is widened so any 4-bit cell index selects a real bit.
  function automatic logic cellFree(input logic [3:0] pos, input logic [8:0] occ);
    logic [15:0] occExt;
    occExt = {7'd0, occ};
    return (pos >= 4'd1) && (pos <= 4'd9) && !occExt[pos - 4'd1];
  endfunction

  assign validX  = reqX && cellFree(posX, board_occ);
  assign validO  = reqO && cellFree(posO, board_occ);
  assign expired = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    turn_d     = turn_q;
    moveCnt_d  = moveCnt_q;
    result_d   = result_q;
    posPlayX_d = posPlayX_q;
    posPlayO_d = posPlayO_q;
    ackX_d     = 1'b0;
    ackO_d     = 1'b0;
    nackX_d    = 1'b0;
    nackO_d    = 1'b0;
    timeout_d  = 1'b0;
    boardRst_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE) begin
          boardRst_d = 1'b1;
        end
        if (start) begin
          state_d    = WAIT_X;
          cnt_d      = '0;
          turn_d     = TURN_X;
          moveCnt_d  = 4'd0;
          result_d   = 2'b00;
          boardRst_d = 1'b1;
        end
      end

      WAIT_X: begin
        cnt_d   = cnt_q + 1'b1;
        nackO_d = reqO;
        if (validX) begin
          state_d    = ISSUE;
          cnt_d      = '0;
          ackX_d     = 1'b1;
          posPlayX_d = posX;
          moveCnt_d  = moveCnt_q + 4'd1;
        end else begin
          nackX_d = reqX;
          if (expired) begin
            state_d   = WAIT_O;
            cnt_d     = '0;
            turn_d    = TURN_O;
            timeout_d = 1'b1;
          end
        end
      end

      WAIT_O: begin
        cnt_d   = cnt_q + 1'b1;
        nackX_d = reqX;
        if (validO) begin
          state_d    = ISSUE;
          cnt_d      = '0;
          ackO_d     = 1'b1;
          posPlayO_d = posO;
          moveCnt_d  = moveCnt_q + 4'd1;
        end else begin
          nackO_d = reqO;
          if (expired) begin
            state_d   = WAIT_X;
            cnt_d     = '0;
            turn_d    = TURN_X;
            timeout_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (win_in != 2'b00) begin
            state_d  = DONE;
            result_d = win_in;
            turn_d   = TURN_NONE;
          end else if (moveCnt_q == 4'd9) begin
            state_d  = DONE;
            result_d = 2'b11;
            turn_d   = TURN_NONE;
          end else if (turn_q == TURN_X) begin
            state_d = WAIT_O;
            turn_d  = TURN_O;
          end else begin
            state_d = WAIT_X;
            turn_d  = TURN_X;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      turn_q     <= TURN_NONE;
      moveCnt_q  <= 4'd0;
      result_q   <= 2'b00;
      posPlayX_q <= 4'd0;
      posPlayO_q <= 4'd0;
      ackX_q     <= 1'b0;
      ackO_q     <= 1'b0;
      nackX_q    <= 1'b0;
      nackO_q    <= 1'b0;
      timeout_q  <= 1'b0;
      boardRst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
      moveCnt_q  <= moveCnt_d;
      result_q   <= result_d;
      posPlayX_q <= posPlayX_d;
      posPlayO_q <= posPlayO_d;
      ackX_q     <= ackX_d;
      ackO_q     <= ackO_d;
      nackX_q    <= nackX_d;
      nackO_q    <= nackO_d;
      timeout_q  <= timeout_d;
      boardRst_q <= boardRst_d;
    end
  end

  // play spans the whole ISSUE stay, which begins in the ack cycle.
  assign play      = (state_q == ISSUE);
  assign game_over = (state_q == DONE);
  assign ackX      = ackX_q;
  assign ackO      = ackO_q;
  assign nackX     = nackX_q;
  assign nackO     = nackO_q;
  assign timeout   = timeout_q;
  assign board_rst = boardRst_q;
  assign pos_playX = posPlayX_q;
  assign pos_play0 = posPlayO_q;
  assign turn      = turn_q;
  assign move_cnt  = moveCnt_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Scoreboard bench for ttt_turn_controller: directed games with a small board model,
// expected events queued by the stimulus and checked by an independent monitor.
module tb_ttt_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       reqX, reqO;
  logic [3:0] posX, posO;
  logic [8:0] board_occ;
  logic [1:0] win_in;
  logic       ackX, ackO, nackX, nackO;
  logic       board_rst, play;
  logic [3:0] pos_playX, pos_play0;
  logic [1:0] turn;
  logic [3:0] move_cnt;
  logic       timeout, game_over;
  logic [1:0] result;

  localparam logic [3:0] EV_ACKX  = 4'd1;
  localparam logic [3:0] EV_NACKX = 4'd2;
  localparam logic [3:0] EV_ACKO  = 4'd3;
  localparam logic [3:0] EV_NACKO = 4'd4;
  localparam logic [3:0] EV_TO    = 4'd5;
  localparam logic [3:0] EV_PLAY  = 4'd6;
  localparam logic [3:0] EV_DONE  = 4'd7;

  typedef struct packed {
    logic [3:0] kind;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
  } ev_t;

  ev_t        expQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [8:0] occ;
  logic [1:0] win;
  int         playLen = 0;
  logic       prevPlay = 1'b0;
  logic       prevGo = 1'b0;

  always #5 clk = ~clk;

  ttt_turn_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .reqX(reqX), .posX(posX), .reqO(reqO), .posO(posO),
    .board_occ(board_occ), .win_in(win_in),
    .ackX(ackX), .ackO(ackO), .nackX(nackX), .nackO(nackO),
    .board_rst(board_rst), .play(play),
    .pos_playX(pos_playX), .pos_play0(pos_play0),
    .turn(turn), .move_cnt(move_cnt), .timeout(timeout),
    .game_over(game_over), .result(result)
  );

  function automatic logic [8:0] cellBit(input logic [3:0] p);
    logic [8:0] one;
    one = 9'd1;
    if (p >= 4'd1 && p <= 4'd9) return one << (p - 4'd1);
    return 9'd0;
  endfunction

  // Board model: occupancy follows accepted moves, cleared by board_rst.
  always @(posedge clk) begin
    if (board_rst) occ <= 9'd0;
    else begin
      if (ackX) occ <= occ | cellBit(pos_playX);
      if (ackO) occ <= occ | cellBit(pos_play0);
    end
  end
  assign board_occ = occ;
  assign win_in    = win;

  function automatic ev_t mkEv(input logic [3:0] k, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  function automatic string kindName(input logic [3:0] k);
    case (k)
      EV_ACKX:  return "ackX_event";
      EV_NACKX: return "nackX_event";
      EV_ACKO:  return "ackO_event";
      EV_NACKO: return "nackO_event";
      EV_TO:    return "timeout_event";
      EV_PLAY:  return "play_length";
      EV_DONE:  return "game_done";
      default:  return "unknown_event";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit(input ev_t obs);
    ev_t exp;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_event: got %0h expected none", obs);
    end else begin
      exp = expQ.pop_front();
      checkOutput(kindName(exp.kind), 32'(obs), 32'(exp));
    end
  endtask

  // Monitor: turns DUT pulses and play/game_over edges into events.
  always @(negedge clk) begin
    if (ackX)    emit(mkEv(EV_ACKX, pos_playX, move_cnt, turn));
    if (nackX)   emit(mkEv(EV_NACKX, 4'd0, move_cnt, turn));
    if (ackO)    emit(mkEv(EV_ACKO, pos_play0, move_cnt, turn));
    if (nackO)   emit(mkEv(EV_NACKO, 4'd0, move_cnt, turn));
    if (timeout) emit(mkEv(EV_TO, 4'd0, move_cnt, turn));
    if (play) playLen++;
    else if (prevPlay) begin
      emit(mkEv(EV_PLAY, 4'(playLen), 4'd0, 2'd0));
      playLen = 0;
    end
    if (game_over && !prevGo) emit(mkEv(EV_DONE, {2'b00, result}, move_cnt, turn));
    prevPlay = play;
    prevGo   = game_over;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name, 32'({ackX, ackO, nackX, nackO, board_rst, play, pos_playX, pos_play0,
                           turn, move_cnt, timeout, game_over, result}),
                32'({4'b0000, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 2'd0}));
  endtask

  task automatic waitTurn(input logic [1:0] t);
    int n = 0;
    while (turn !== t && n < 50) begin
      tick;
      n++;
    end
    if (turn !== t) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_turn: got %0h expected %0h", turn, t);
    end
  endtask

  task automatic waitGameOver;
    int n = 0;
    while (game_over !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    checkOutput("game_over_reached", 32'(game_over), 32'd1);
  endtask

  task automatic startGame;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("start_board_rst_high", 32'(board_rst), 32'd1);
    checkOutput("start_state", 32'({turn, move_cnt, game_over}), 32'({2'b01, 4'd0, 1'b0}));
    tick;
    checkOutput("start_board_rst_low", 32'(board_rst), 32'd0);
  endtask

  task automatic doX(input logic [3:0] p);
    reqX = 1'b1; posX = p;
    tick;
    reqX = 1'b0;
  endtask

  task automatic doO(input logic [3:0] p);
    reqO = 1'b1; posO = p;
    tick;
    reqO = 1'b0;
  endtask

  task automatic moveX(input logic [3:0] p, input logic [3:0] cnt);
    waitTurn(2'b01);
    expQ.push_back(mkEv(EV_ACKX, p, cnt, 2'b01));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    doX(p);
  endtask

  task automatic moveO(input logic [3:0] p, input logic [3:0] cnt);
    waitTurn(2'b10);
    expQ.push_back(mkEv(EV_ACKO, p, cnt, 2'b10));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    doO(p);
  endtask

  task automatic applyStimulus;
    rst = 1'b1; start = 1'b0; reqX = 1'b0; reqO = 1'b0;
    posX = 4'd0; posO = 4'd0; win = 2'b00;
    tick;
    tick;
    checkResetState("reset_state");
    rst = 1'b0;
    tick;

    // Game 1: invalid cells, off-turn and simultaneous requests, then O wins.
    startGame;
    expQ.push_back(mkEv(EV_NACKX, 4'd0, 4'd0, 2'b01));
    doX(4'd0);
    expQ.push_back(mkEv(EV_NACKX, 4'd0, 4'd0, 2'b01));
    doX(4'd12);
    expQ.push_back(mkEv(EV_NACKO, 4'd0, 4'd0, 2'b01));
    doO(4'd3);
    checkOutput("offturn_turn_held", 32'(turn), 32'd1);
    expQ.push_back(mkEv(EV_ACKX, 4'd5, 4'd1, 2'b01));
    expQ.push_back(mkEv(EV_NACKO, 4'd0, 4'd1, 2'b01));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    reqX = 1'b1; posX = 4'd5; reqO = 1'b1; posO = 4'd7;
    tick;
    reqX = 1'b0; reqO = 1'b0;
    waitTurn(2'b10);
    expQ.push_back(mkEv(EV_NACKO, 4'd0, 4'd1, 2'b10));
    doO(4'd5);
    checkOutput("occupied_no_play", 32'({play, move_cnt}), 32'({1'b0, 4'd1}));
    moveO(4'd1, 4'd2);
    moveX(4'd9, 4'd3);
    moveO(4'd2, 4'd4);
    moveX(4'd7, 4'd5);
    expQ.push_back(mkEv(EV_ACKO, 4'd3, 4'd6, 2'b10));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    expQ.push_back(mkEv(EV_DONE, 4'd2, 4'd6, 2'b00));
    waitTurn(2'b10);
    doO(4'd3);
    win = 2'b10;
    waitGameOver;
    tick;
    checkOutput("result_held", 32'(result), 32'd2);

    // Game 2: occupied O cell, turn timeout, late valid request, reset in ISSUE.
    win = 2'b00;
    startGame;
    moveX(4'd5, 4'd1);
    waitTurn(2'b10);
    expQ.push_back(mkEv(EV_NACKO, 4'd0, 4'd1, 2'b10));
    doO(4'd5);
    expQ.push_back(mkEv(EV_ACKO, 4'd4, 4'd2, 2'b10));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    doO(4'd4);
    checkOutput("ackO_pos_play0", 32'(pos_play0), 32'd4);
    waitTurn(2'b01);
    expQ.push_back(mkEv(EV_TO, 4'd0, 4'd2, 2'b10));
    repeat (199) tick;
    checkOutput("timeout_not_early", 32'(timeout), 32'd0);
    tick;
    checkOutput("timeout_pulse", 32'({timeout, turn, move_cnt}), 32'({1'b1, 2'b10, 4'd2}));
    repeat (199) tick;
    expQ.push_back(mkEv(EV_ACKO, 4'd6, 4'd3, 2'b10));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    doO(4'd6);
    checkOutput("late_request_no_timeout", 32'(timeout), 32'd0);
    waitTurn(2'b01);
    expQ.push_back(mkEv(EV_ACKX, 4'd1, 4'd4, 2'b01));
    expQ.push_back(mkEv(EV_PLAY, 4'd1, 4'd0, 2'd0));
    doX(4'd1);
    checkOutput("issue_play_high", 32'(play), 32'd1);
    rst = 1'b1;
    tick;
    checkResetState("reset_during_issue");
    tick;
    rst = 1'b0;
    tick;

    // Game 3: nine moves, no winner, then a fresh start.
    startGame;
    moveX(4'd1, 4'd1);
    moveO(4'd2, 4'd2);
    moveX(4'd3, 4'd3);
    moveO(4'd5, 4'd4);
    moveX(4'd8, 4'd5);
    moveO(4'd7, 4'd6);
    moveX(4'd4, 4'd7);
    moveO(4'd6, 4'd8);
    waitTurn(2'b01);
    expQ.push_back(mkEv(EV_ACKX, 4'd9, 4'd9, 2'b01));
    expQ.push_back(mkEv(EV_PLAY, 4'd2, 4'd0, 2'd0));
    expQ.push_back(mkEv(EV_DONE, 4'd3, 4'd9, 2'b00));
    doX(4'd9);
    waitGameOver;
    startGame;
    repeat (10) tick;
  endtask

  initial begin
    applyStimulus;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
